kcpsmx_io_responder: RTL and testbench



---
 rtl/kcpsmx_io_responder_pkg.sv | 31 +++
 rtl/kcpsmx_io_fifo.sv | 63 ++++++
 rtl/kcpsmx_io_responder.sv | 177 +++++++++++++++++
 tb/tb_kcpsmx_io_responder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/kcpsmx_io_responder_pkg.sv
// Shared definitions for the kcpsmx I/O responder: register offsets,
// STATUS bit positions and the sticky-flag update helper.
package kcpsmx3_inc;

  // Register offsets relative to BASE_ADDR
  typedef enum logic [2:0] {
    IO_GPIO_OUT     = 3'd0,
    IO_GPIO_IN      = 3'd1,
    IO_TIMER_RELOAD = 3'd2,
    IO_STATUS       = 3'd3,
    IO_IRQ_EN       = 3'd4,
    IO_RX_DATA      = 3'd5
  } io_reg_t;

  localparam logic [7:0] IO_NUM_REGS = 8'd6;

  // STATUS bit positions
  localparam int ST_TIMER     = 0;
  localparam int ST_GPIO_RISE = 1;
  localparam int ST_NOT_EMPTY = 2;
  localparam int ST_FULL      = 3;
  localparam int ST_OVERFLOW  = 4;

  // A set in the same cycle as a clear wins, so the flag stays 1
  function automatic logic [4:0] sticky_next(input logic [4:0] q,
                                             input logic [4:0] set,
                                             input logic [4:0] clr);
    return set | (q & ~clr);
  endfunction

endpackage

// File: rtl/kcpsmx_io_fifo.sv
// Synchronous receive FIFO: push/pop, full/empty flags, head data and a
// drop pulse when a push is refused because the FIFO is full.
module kcpsmx_io_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         empty_o,
  output logic         full_o,
  output logic         drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pop_ok_s, push_ok_s;

  assign empty_o   = (cnt_q == {CW{1'b0}});
  assign full_o    = (cnt_q == CW'(DEPTH));
  assign dout_o    = mem_q[rd_ptr_q];
  // A pop on an empty FIFO does nothing; a push on a full FIFO is accepted
  // only if a real pop frees a slot in the same cycle.
  assign pop_ok_s  = pop_i & ~empty_o;
  assign push_ok_s = push_i & (~full_o | pop_ok_s);
  assign drop_o    = push_i & ~push_ok_s;

  // Next-state pointers and occupancy; pointers wrap since DEPTH is 2^AW
  always_comb begin
    wr_ptr_d = push_ok_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CW'(push_ok_s) - CW'(pop_ok_s);
  end

  // Pointer and count registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      cnt_q    <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk_i) begin
    if (push_ok_s && !reset_i) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/kcpsmx_io_responder.sv
// kcpsmx I/O port responder: GPIO, prescaled down-counting timer, interrupt
// with acknowledge, and an optional RX FIFO enabled by KCPSMX_IO_RXFIFO_EN.
module kcpsmx_io_responder
  import kcpsmx3_inc::*;
#(
  parameter logic [7:0] BASE_ADDR  = 8'h00,
  parameter int         PRESCALE   = 16,
  parameter int         FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] port_id,
  input  logic       write_strobe,
  input  logic [7:0] out_port,
  input  logic       read_strobe,
  output logic [7:0] in_port,
  output logic       interrupt,
  input  logic       interrupt_ack,
  input  logic [7:0] gpio_in,
  output logic [7:0] gpio_out,
  input  logic [7:0] rx_data,
  input  logic       rx_strobe
);

  localparam int            PW          = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRESC_LAST  = PW'(PRESCALE - 1);
  localparam logic [4:0]    STICKY_MASK = (5'd1 << ST_TIMER) | (5'd1 << ST_GPIO_RISE) |
                                          (5'd1 << ST_OVERFLOW);
`ifdef KCPSMX_IO_RXFIFO_EN
  localparam logic [4:0]    IRQ_MASK    = 5'h1F;
`else
  localparam logic [4:0]    IRQ_MASK    = 5'h03;
`endif

  logic [7:0]    gpio_out_q, gpio_out_d;
  logic [4:0]    irq_en_q, irq_en_d;
  logic [7:0]    reload_q, reload_d;
  logic [7:0]    count_q, count_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    sticky_q, sticky_d;
  logic          interrupt_q;
  logic [7:0]    sync1_q, sync2_q, prev_q;

  logic [7:0] off_s;
  logic       hit_s, rd_s, wr_s, pop_s, tick_s, timer_set_s, rise_s;
  io_reg_t    reg_s;
  logic [7:0] status_s;
  logic [4:0] set_s, clr_s;
  logic [7:0] fifo_head_s;
  logic       fifo_empty_s, fifo_full_s, fifo_drop_s;

  // Address decode: offset wraps modulo 256 so BASE_ADDR may sit anywhere
  assign off_s  = port_id - BASE_ADDR;
  assign hit_s  = (off_s < IO_NUM_REGS);
  assign reg_s  = io_reg_t'(off_s[2:0]);
  assign rd_s   = read_strobe & hit_s & ~reset;
  assign wr_s   = write_strobe & hit_s & ~reset;
  assign pop_s  = rd_s & (reg_s == IO_RX_DATA) & ~fifo_empty_s;

  assign tick_s      = (presc_q == PRESC_LAST);
  assign timer_set_s = tick_s & (reload_q != 8'd0) & (count_q == 8'd1);
  assign rise_s      = |(sync2_q & ~prev_q);

  assign status_s = {3'b000, sticky_q[ST_OVERFLOW], fifo_full_s, ~fifo_empty_s,
                     sticky_q[ST_GPIO_RISE], sticky_q[ST_TIMER]};

  assign gpio_out  = gpio_out_q;
  assign interrupt = interrupt_q;

`ifdef KCPSMX_IO_RXFIFO_EN
  kcpsmx_io_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (rx_strobe),
    .pop_i   (pop_s),
    .din_i   (rx_data),
    .dout_o  (fifo_head_s),
    .empty_o (fifo_empty_s),
    .full_o  (fifo_full_s),
    .drop_o  (fifo_drop_s)
  );
`else
  logic unused_s;
  assign fifo_head_s  = 8'h00;
  assign fifo_empty_s = 1'b1;
  assign fifo_full_s  = 1'b0;
  assign fifo_drop_s  = 1'b0;
  assign unused_s     = ^{rx_data, rx_strobe, pop_s, FIFO_DEPTH[0]};
`endif

  // Combinational read mux; zero whenever no mapped register is being read
  always_comb begin
    in_port = 8'h00;
    if (rd_s) begin
      case (reg_s)
        IO_GPIO_OUT:     in_port = gpio_out_q;
        IO_GPIO_IN:      in_port = sync2_q;
        IO_TIMER_RELOAD: in_port = reload_q;
        IO_STATUS:       in_port = status_s;
        IO_IRQ_EN:       in_port = {3'b000, irq_en_q};
        IO_RX_DATA:      in_port = fifo_empty_s ? 8'h00 : fifo_head_s;
        default:         in_port = 8'h00;
      endcase
    end else begin
      in_port = 8'h00;
    end
  end

  // Register writes, timer stepping and sticky flag next-state
  always_comb begin
    gpio_out_d = gpio_out_q;
    irq_en_d   = irq_en_q;
    reload_d   = reload_q;
    clr_s      = 5'd0;
    if (wr_s) begin
      case (reg_s)
        IO_GPIO_OUT:     gpio_out_d = out_port;
        IO_TIMER_RELOAD: reload_d   = out_port;
        IO_STATUS:       clr_s      = out_port[4:0];
        IO_IRQ_EN:       irq_en_d   = out_port[4:0] & IRQ_MASK;
        default:         gpio_out_d = gpio_out_q;
      endcase
    end else begin
      clr_s = 5'd0;
    end
    if (interrupt_ack) begin
      clr_s = clr_s | irq_en_q;
    end else begin
      clr_s = clr_s;
    end

    presc_d = tick_s ? {PW{1'b0}} : presc_q + PW'(1);
    count_d = count_q;
    if (wr_s && (reg_s == IO_TIMER_RELOAD)) begin
      presc_d = {PW{1'b0}};
      count_d = out_port;
    end else if (tick_s && (reload_q != 8'd0)) begin
      count_d = (count_q == 8'd1) ? reload_q : count_q - 8'd1;
    end else begin
      count_d = count_q;
    end

    set_s    = {fifo_drop_s, 2'b00, rise_s, timer_set_s};
    sticky_d = sticky_next(sticky_q, set_s, clr_s & STICKY_MASK) & STICKY_MASK;
  end

  // State registers, synchronizers and registered interrupt request
  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_out_q  <= 8'h00;
      irq_en_q    <= 5'd0;
      reload_q    <= 8'h00;
      count_q     <= 8'h00;
      presc_q     <= {PW{1'b0}};
      sticky_q    <= 5'd0;
      interrupt_q <= 1'b0;
      sync1_q     <= 8'h00;
      sync2_q     <= 8'h00;
      prev_q      <= 8'h00;
    end else begin
      gpio_out_q  <= gpio_out_d;
      irq_en_q    <= irq_en_d;
      reload_q    <= reload_d;
      count_q     <= count_d;
      presc_q     <= presc_d;
      sticky_q    <= sticky_d;
      interrupt_q <= |(status_s[4:0] & irq_en_q);
      sync1_q     <= gpio_in;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
    end
  end

endmodule

// File: tb/tb_kcpsmx_io_responder.sv
// Directed self-checking bench for kcpsmx_io_responder with a read-data
// scoreboard; FIFO steps follow KCPSMX_IO_RXFIFO_EN.
module tb_kcpsmx_io_responder;

  localparam logic [7:0] BASE = 8'h10;
`ifdef KCPSMX_IO_RXFIFO_EN
  localparam logic [7:0] IRQ_EN_ALL = 8'h1F;
`else
  localparam logic [7:0] IRQ_EN_ALL = 8'h03;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] port_id = 8'h00;
  logic       write_strobe = 1'b0;
  logic [7:0] out_port = 8'h00;
  logic       read_strobe = 1'b0;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack = 1'b0;
  logic [7:0] gpio_in = 8'h00;
  logic [7:0] gpio_out;
  logic [7:0] rx_data = 8'h00;
  logic       rx_strobe = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  string      tag_q[$];

  kcpsmx_io_responder #(
    .BASE_ADDR  (BASE),
    .PRESCALE   (16),
    .FIFO_DEPTH (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .port_id       (port_id),
    .write_strobe  (write_strobe),
    .out_port      (out_port),
    .read_strobe   (read_strobe),
    .in_port       (in_port),
    .interrupt     (interrupt),
    .interrupt_ack (interrupt_ack),
    .gpio_in       (gpio_in),
    .gpio_out      (gpio_out),
    .rx_data       (rx_data),
    .rx_strobe     (rx_strobe)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_reg(input logic [7:0] off, input logic [7:0] data);
    port_id      = 8'(BASE + off);
    out_port     = data;
    write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
    port_id      = 8'h00;
    out_port     = 8'h00;
  endtask

  task automatic push_rx(input logic [7:0] data);
    rx_data   = data;
    rx_strobe = 1'b1;
    tick();
    rx_strobe = 1'b0;
  endtask

  // Queue the expected read data, perform the read, compare at mid-cycle
  task automatic exp_read(input logic [7:0] off, input logic [7:0] exp, input string tag,
                          input logic push_en = 1'b0, input logic [7:0] push_data = 8'h00);
    logic [7:0] e;
    string      t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    port_id     = 8'(BASE + off);
    read_strobe = 1'b1;
    rx_strobe   = push_en;
    rx_data     = push_data;
    #4;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, in_port, e);
    tick();
    read_strobe = 1'b0;
    rx_strobe   = 1'b0;
    port_id     = 8'h00;
  endtask

  initial begin
    // Reset state
    tick(2);
    check("rst_gpio_out", gpio_out, 8'h00);
    check("rst_irq", {7'd0, interrupt}, 8'h00);
    check("rst_in_port", in_port, 8'h00);
    reset = 1'b0;
    exp_read(8'd3, 8'h00, "rst_status");

    // GPIO out and decode
    write_reg(8'd0, 8'hA5);
    check("gpio_out_wr", gpio_out, 8'hA5);
    exp_read(8'd0, 8'hA5, "gpio_out_rd");
    exp_read(8'd7, 8'h00, "unmapped_rd");
    port_id = 8'h00; read_strobe = 1'b1; #4;
    check("below_base_rd", in_port, 8'h00);
    tick(); read_strobe = 1'b0;
    write_reg(8'd1, 8'hFF);
    exp_read(8'd1, 8'h00, "ro_write_ignored");

    // IRQ enable mask and GPIO rise interrupt
    write_reg(8'd4, 8'hFF);
    exp_read(8'd4, IRQ_EN_ALL, "irq_en_mask");
    write_reg(8'd4, 8'h02);
    gpio_in = 8'h01;
    tick(2);
    exp_read(8'd3, 8'h00, "rise_before_sync");
    check("irq_not_yet", {7'd0, interrupt}, 8'h00);
    tick();
    check("irq_rise", {7'd0, interrupt}, 8'h01);
    exp_read(8'd3, 8'h02, "status_rise");
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
    check("irq_ack_edge", {7'd0, interrupt}, 8'h01);
    tick();
    check("irq_after_ack", {7'd0, interrupt}, 8'h00);
    exp_read(8'd3, 8'h00, "status_acked");
    exp_read(8'd1, 8'h01, "gpio_in_rd");
    write_reg(8'd4, 8'h00);

    // Timer: reload 3 at prescale 16 -> flag every 48 cycles
    write_reg(8'd2, 8'h03);
    tick(47);
    exp_read(8'd3, 8'h00, "timer_t47");
    exp_read(8'd3, 8'h01, "timer_t48");
    write_reg(8'd3, 8'h01);
    exp_read(8'd3, 8'h00, "timer_w1c");
    tick(44);
    exp_read(8'd3, 8'h00, "timer_t95");
    exp_read(8'd3, 8'h01, "timer_t96");
    tick(46);
    write_reg(8'd3, 8'h01);
    exp_read(8'd3, 8'h01, "timer_set_wins");
    write_reg(8'd3, 8'h01);
    exp_read(8'd3, 8'h00, "timer_clear2");
    write_reg(8'd2, 8'h00);
    exp_read(8'd2, 8'h00, "reload_zero_rd");
    tick(100);
    exp_read(8'd3, 8'h00, "timer_stopped");

`ifdef KCPSMX_IO_RXFIFO_EN
    // FIFO ordering and empty read
    push_rx(8'h11); push_rx(8'h22); push_rx(8'h33);
    exp_read(8'd3, 8'h04, "fifo_not_empty");
    exp_read(8'd5, 8'h11, "fifo_rd0");
    exp_read(8'd5, 8'h22, "fifo_rd1");
    exp_read(8'd5, 8'h33, "fifo_rd2");
    exp_read(8'd5, 8'h00, "fifo_rd_empty");
    exp_read(8'd3, 8'h00, "fifo_empty_status");
    // Overflow, then simultaneous push/pop while full
    for (int i = 0; i < 9; i++) push_rx(8'(8'h40 + i));
    exp_read(8'd3, 8'h1C, "fifo_overflow");
    write_reg(8'd3, 8'h10);
    exp_read(8'd3, 8'h0C, "fifo_ovf_w1c");
    exp_read(8'd5, 8'h40, "fifo_full_pushpop", 1'b1, 8'h99);
    exp_read(8'd3, 8'h0C, "fifo_no_reovf");
    for (int i = 1; i < 8; i++) exp_read(8'd5, 8'(8'h40 + i), "fifo_drain");
    exp_read(8'd5, 8'h99, "fifo_drain_last");
    exp_read(8'd5, 8'h00, "fifo_empty_pushpop", 1'b1, 8'h77);
    exp_read(8'd5, 8'h77, "fifo_push_landed");
    exp_read(8'd3, 8'h00, "fifo_final_status");
`else
    push_rx(8'h11);
    exp_read(8'd3, 8'h00, "nofifo_status");
    exp_read(8'd5, 8'h00, "nofifo_rd");
`endif

    // Reset mid-operation with a coincident write
    write_reg(8'd2, 8'h07);
    exp_read(8'd2, 8'h07, "reload_rd");
    reset = 1'b1;
    port_id = 8'(BASE + 8'd0); out_port = 8'h3C; write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0; reset = 1'b0;
    check("midrst_gpio_out", gpio_out, 8'h00);
    exp_read(8'd2, 8'h00, "midrst_reload");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
